// File: rtl/btn_evt_pkg.sv
// rtl/btn_evt_pkg.sv - shared event kinds and record-width helpers for the button event arbiter
package btn_evt_pkg;

  // Width of the kind field inside a queued event record
  localparam int KIND_W = 2;

  typedef enum logic [KIND_W-1:0] {
    EVT_SHORT  = 2'd0,
    EVT_LONG   = 2'd1,
    EVT_REPEAT = 2'd2
  } evt_kind_t;

  // Bits needed to carry a button index (at least one, even for a single button)
  function automatic int btn_idx_w(input int n_btn);
    return (n_btn > 1) ? $clog2(n_btn) : 1;
  endfunction

  // Width of one queued event record: {btn, kind}
  function automatic int evt_rec_w(input int n_btn);
    return btn_idx_w(n_btn) + KIND_W;
  endfunction

endpackage

// File: rtl/btn_event_arbiter_if.sv
// rtl/btn_event_arbiter_if.sv - show-ahead event handshake between the arbiter and its consumer
interface btn_event_arbiter_if #(
  parameter int N_BTN = 5
);
  import btn_evt_pkg::*;

  localparam int BTN_W = btn_idx_w(N_BTN);

  logic             evt_valid_o;
  logic             evt_ready_i;
  logic [BTN_W-1:0] evt_btn_o;
  evt_kind_t        evt_kind_o;

  modport master (
    output evt_valid_o,
    output evt_btn_o,
    output evt_kind_o,
    input  evt_ready_i
  );

  modport slave (
    input  evt_valid_o,
    input  evt_btn_o,
    input  evt_kind_o,
    output evt_ready_i
  );

endinterface

// File: rtl/btn_evt_fifo.sv
// rtl/btn_evt_fifo.sv - synchronous show-ahead event queue with occupancy count
module btn_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     head_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign head_valid = (level != '0);
  assign full       = (level == DEPTH_C);
  assign do_push    = push & ~full;
  assign do_pop     = pop & head_valid;

  // Head record is zeroed while empty so downstream never sees stale data
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  // Storage write; contents are qualified by level so they need no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks push minus pop
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/btn_event_arbiter.sv
// rtl/btn_event_arbiter.sv - collects per-button tap/long/repeat events and serialises them round-robin
module btn_event_arbiter
  import btn_evt_pkg::*;
#(
  parameter int N_BTN         = 5,
  parameter int FIFO_DEPTH    = 8,
  parameter int REPEAT_PERIOD = 6250000
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic [N_BTN-1:0]              short_i,
  input  logic [N_BTN-1:0]              long_i,
  input  logic [N_BTN-1:0]              held_i,
  output logic                          ovf_o,
  input  logic                          ovf_clr_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  btn_event_arbiter_if.master           evt
);

  localparam int BTN_W = btn_idx_w(N_BTN);
  localparam int REC_W = evt_rec_w(N_BTN);
  localparam int CNT_W = $clog2(REPEAT_PERIOD + 1);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(REPEAT_PERIOD);
  localparam logic [BTN_W-1:0] LAST_BTN = BTN_W'(N_BTN - 1);

  logic [N_BTN-1:0] pend_short;
  logic [N_BTN-1:0] pend_long;
  logic [N_BTN-1:0] pend_rep;

  logic [N_BTN-1:0] rep_armed;
  logic [N_BTN-1:0] rep_fire;
  logic [CNT_W-1:0] rep_cnt [N_BTN];

  logic [BTN_W-1:0] rr_ptr;
  logic             gnt_valid;
  logic [BTN_W-1:0] gnt_btn;
  evt_kind_t        gnt_kind;
  logic [N_BTN-1:0] gnt_short_m;
  logic [N_BTN-1:0] gnt_long_m;
  logic [N_BTN-1:0] gnt_rep_m;
  logic [N_BTN-1:0] drop_m;

  logic             fifo_full;
  logic             head_valid;
  logic [REC_W-1:0] push_rec;
  logic [REC_W-1:0] head_rec;

  // A repeat fires when an armed, still-held button has counted a full period
  always_comb begin
    rep_fire = '0;
    for (int b = 0; b < N_BTN; b++) begin
      rep_fire[b] = rep_armed[b] & held_i[b] & (rep_cnt[b] == PERIOD_C);
    end
  end

  // Repeat timers: long press arms and counts from 1; release disarms at once
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rep_armed <= '0;
      for (int b = 0; b < N_BTN; b++) begin
        rep_cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < N_BTN; b++) begin
        if (long_i[b]) begin
          rep_armed[b] <= 1'b1;
          rep_cnt[b]   <= CNT_W'(1);
        end else if (!held_i[b]) begin
          rep_armed[b] <= 1'b0;
          rep_cnt[b]   <= '0;
        end else if (rep_armed[b]) begin
          rep_cnt[b]   <= rep_fire[b] ? CNT_W'(1) : rep_cnt[b] + CNT_W'(1);
        end
      end
    end
  end

  // Round-robin search from rr_ptr; first button with anything pending wins,
  // LONG before SHORT before REPEAT within that button
  always_comb begin
    int               idx;
    logic [BTN_W-1:0] idx_b;
    gnt_valid = 1'b0;
    gnt_btn   = '0;
    gnt_kind  = EVT_SHORT;
    idx       = 0;
    idx_b     = '0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_BTN) begin
        idx = idx - N_BTN;
      end
      idx_b = BTN_W'(idx);
      if (!gnt_valid && !fifo_full &&
          (pend_long[idx_b] | pend_short[idx_b] | pend_rep[idx_b])) begin
        gnt_valid = 1'b1;
        gnt_btn   = idx_b;
        if (pend_long[idx_b]) begin
          gnt_kind = EVT_LONG;
        end else if (pend_short[idx_b]) begin
          gnt_kind = EVT_SHORT;
        end else begin
          gnt_kind = EVT_REPEAT;
        end
      end
    end
  end

  // One-hot masks of the pending bit being granted this cycle
  always_comb begin
    gnt_short_m = '0;
    gnt_long_m  = '0;
    gnt_rep_m   = '0;
    if (gnt_valid) begin
      case (gnt_kind)
        EVT_LONG:   gnt_long_m[gnt_btn]  = 1'b1;
        EVT_REPEAT: gnt_rep_m[gnt_btn]   = 1'b1;
        default:    gnt_short_m[gnt_btn] = 1'b1;
      endcase
    end
  end

  // A pulse is lost only when its bit is already set and not leaving this cycle
  assign drop_m = (short_i  & pend_short & ~gnt_short_m)
                | (long_i   & pend_long  & ~gnt_long_m)
                | (rep_fire & pend_rep   & ~gnt_rep_m);

  // Pending bits, round-robin pointer and sticky overflow flag
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pend_short <= '0;
      pend_long  <= '0;
      pend_rep   <= '0;
      rr_ptr     <= '0;
      ovf_o      <= 1'b0;
    end else begin
      pend_short <= (pend_short & ~gnt_short_m) | short_i;
      pend_long  <= (pend_long  & ~gnt_long_m)  | long_i;
      pend_rep   <= (pend_rep   & ~gnt_rep_m)   | rep_fire;
      if (gnt_valid) begin
        rr_ptr <= (gnt_btn == LAST_BTN) ? '0 : gnt_btn + BTN_W'(1);
      end
      if (|drop_m) begin
        ovf_o <= 1'b1;
      end else if (ovf_clr_i) begin
        ovf_o <= 1'b0;
      end
    end
  end

  assign push_rec = {gnt_btn, gnt_kind};

  btn_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk        (clk),
    .arst_n     (arst_n),
    .push       (gnt_valid),
    .push_data  (push_rec),
    .pop        (evt.evt_ready_i),
    .head_data  (head_rec),
    .head_valid (head_valid),
    .full       (fifo_full),
    .level      (level_o)
  );

  assign evt.evt_valid_o = head_valid;
  assign evt.evt_btn_o   = head_rec[REC_W-1:KIND_W];
  assign evt.evt_kind_o  = evt_kind_t'(head_rec[KIND_W-1:0]);

endmodule
